// File: rtl/temperature_anomaly_detector.sv
// temperature_anomaly_detector
// Sliding-window (DEPTH = 2**WINDOW_LOG2) floor-mean tracker that flags samples
// deviating from the window average by more than THRESHOLD LSBs.
// Each accepted sample occupies two cycles:
//   - E0 (accept): the deviation is checked and the window is updated.
//   - E1 (UPDATE): the new average is published.
// A sample that arrives during UPDATE is dropped and reported on overrun.
// Optional feature macro: ANOMALY_STICKY_EN adds anomalyClear/anomalyLatched.
module temperature_anomaly_detector #(
  parameter int TEMP_WIDTH  = 16,
  parameter int WINDOW_LOG2 = 4,
  parameter int THRESHOLD   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  temperatureReady,
  input  logic [TEMP_WIDTH-1:0] temperature,
`ifdef ANOMALY_STICKY_EN
  input  logic                  anomalyClear,
  output logic                  anomalyLatched,
`endif
  output logic [TEMP_WIDTH-1:0] average,
  output logic                  averageValid,
  output logic                  resultValid,
  output logic                  anomaly,
  output logic                  overrun
);

  localparam int DEPTH = 1 << WINDOW_LOG2;
  localparam int SUM_W = TEMP_WIDTH + WINDOW_LOG2;
  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
  localparam logic [TEMP_WIDTH:0]   THR_L    = (TEMP_WIDTH+1)'(THRESHOLD);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    RUN    = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic                    w_accept;
  logic                    w_drop;
  logic                    w_update;

  logic [TEMP_WIDTH-1:0]   r_buf [DEPTH];
  logic [WINDOW_LOG2-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]        r_fill_cnt;
  logic [SUM_W-1:0]        r_sum;
  logic [SUM_W-1:0]        w_sum_next;
  logic [TEMP_WIDTH-1:0]   r_average;
  logic                    r_avg_valid;
  logic                    r_result_valid;
  logic                    r_anomaly;
  logic                    r_overrun;

  logic signed [TEMP_WIDTH:0] w_diff;
  logic [TEMP_WIDTH:0]        w_dev_mag;
  logic                       w_is_anom;

  // Magnitude of a signed deviation; the operands are unsigned TEMP_WIDTH
  // values, so the most negative code can never occur and negation is safe.
  function automatic logic [TEMP_WIDTH:0] abs_mag(input logic signed [TEMP_WIDTH:0] d);
    logic signed [TEMP_WIDTH:0] neg;
    neg = -d;
    return d[TEMP_WIDTH] ? $unsigned(neg) : $unsigned(d);
  endfunction

  // Deviation of the incoming sample against the average held before it.
  always_comb begin
    w_diff    = $signed({1'b0, temperature}) - $signed({1'b0, r_average});
    w_dev_mag = abs_mag(w_diff);
    w_is_anom = (r_state == RUN) && (w_dev_mag > THR_L);
  end

  // Running sum: add the new sample and subtract the one being evicted.
  // Evicted entries are zero while filling, so the sum stays exact.
  always_comb begin
    w_sum_next = r_sum + SUM_W'(temperature) - SUM_W'(r_buf[r_wr_ptr]);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FILL;
    else        r_state <= w_next_state;
  end

  // Next-state and control decode.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    w_update     = 1'b0;
    case (r_state)
      FILL, RUN: begin
        if (temperatureReady) begin
          w_accept     = 1'b1;
          w_next_state = UPDATE;
        end
      end
      UPDATE: begin
        w_update     = 1'b1;
        w_drop       = temperatureReady;
        w_next_state = (r_fill_cnt == CNT_FULL) ? RUN : FILL;
      end
      default: w_next_state = FILL;
    endcase
  end

  // Sample window storage, cleared on reset so a refill starts from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      r_buf[r_wr_ptr] <= temperature;
    end
  end

  // Write pointer, saturating fill counter and running sum, advanced on accept.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_fill_cnt <= '0;
      r_sum      <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + WINDOW_LOG2'(1);
      r_sum    <= w_sum_next;
      if (r_fill_cnt != CNT_FULL) r_fill_cnt <= r_fill_cnt + CNT_W'(1);
    end
  end

  // Publish the floor mean in UPDATE; validity latches once the window is full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_average   <= '0;
      r_avg_valid <= 1'b0;
    end else if (w_update) begin
      r_average <= r_sum[SUM_W-1:WINDOW_LOG2];
      if (r_fill_cnt == CNT_FULL) r_avg_valid <= 1'b1;
    end
  end

  // Result/overrun pulses; the anomaly flag holds until the next result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_result_valid <= 1'b0;
      r_anomaly      <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_result_valid <= w_accept;
      r_overrun      <= w_drop;
      if (w_accept) r_anomaly <= w_is_anom;
    end
  end

`ifdef ANOMALY_STICKY_EN
  logic r_anom_latched;

  // Sticky anomaly: a new anomaly wins over a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                            r_anom_latched <= 1'b0;
    else if (r_result_valid && r_anomaly)  r_anom_latched <= 1'b1;
    else if (anomalyClear)                 r_anom_latched <= 1'b0;
  end

  assign anomalyLatched = r_anom_latched;
`endif

  assign average      = r_average;
  assign averageValid = r_avg_valid;
  assign resultValid  = r_result_valid;
  assign anomaly      = r_anomaly;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_temperature_anomaly_detector.sv
// Testbench for temperature_anomaly_detector: reference window model feeds a
// scoreboard queue; scenario tasks drive samples and compare DUT results.
module tb_temperature_anomaly_detector;

  localparam int TW    = 16;
  localparam int DEPTH = 16;
  localparam int THR   = 256;

  logic          clk = 1'b0;
  logic          reset;
  logic          temperatureReady;
  logic [TW-1:0] temperature;
  logic [TW-1:0] average;
  logic          averageValid;
  logic          resultValid;
  logic          anomaly;
  logic          overrun;
`ifdef ANOMALY_STICKY_EN
  logic          anomalyClear;
  logic          anomalyLatched;
  bit            clr_with_rv = 1'b0;
`endif

  temperature_anomaly_detector #(
    .TEMP_WIDTH(TW), .WINDOW_LOG2(4), .THRESHOLD(THR)
  ) dut (
    .clk(clk),
    .reset(reset),
    .temperatureReady(temperatureReady),
    .temperature(temperature),
`ifdef ANOMALY_STICKY_EN
    .anomalyClear(anomalyClear),
    .anomalyLatched(anomalyLatched),
`endif
    .average(average),
    .averageValid(averageValid),
    .resultValid(resultValid),
    .anomaly(anomaly),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic          anom;
    logic [TW-1:0] avg;
    logic          avgv;
  } exp_t;
  exp_t sb_q[$];

  int mdl_buf[DEPTH];
  int mdl_sum, mdl_ptr, mdl_fill, mdl_avg;
  bit mdl_avgv;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl_buf[i] = 0;
    mdl_sum = 0; mdl_ptr = 0; mdl_fill = 0; mdl_avg = 0; mdl_avgv = 1'b0;
    sb_q.delete();
  endtask

  task automatic model_accept(input int v, output exp_t e);
    int dev;
    dev = v - mdl_avg;
    if (dev < 0) dev = -dev;
    e.anom = (mdl_fill == DEPTH) && (dev > THR);
    mdl_sum = mdl_sum + v - mdl_buf[mdl_ptr];
    mdl_buf[mdl_ptr] = v;
    mdl_ptr = (mdl_ptr + 1) % DEPTH;
    if (mdl_fill < DEPTH) mdl_fill++;
    mdl_avg = mdl_sum / DEPTH;
    if (mdl_fill == DEPTH) mdl_avgv = 1'b1;
    e.avg  = TW'(mdl_avg);
    e.avgv = mdl_avgv;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    temperatureReady = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // One sample through the DUT with its expected result taken from the queue.
  task automatic send(input int v, input int gap);
    exp_t e, got;
    bit   seen;
    @(negedge clk);
    temperature = TW'(v);
    temperatureReady = 1'b1;
    model_accept(v, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1 temperatureReady = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      if (resultValid === 1'b1) seen = 1'b1;
    end
    got = sb_q.pop_front();
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rv_timeout sample=%0d resultValid never rose", v);
    end
`ifdef ANOMALY_STICKY_EN
    if (clr_with_rv) anomalyClear = 1'b1;
`endif
    n_tests++;
    if (anomaly !== got.anom) begin
      n_fail++;
      $display("FAIL anomaly sample=%0d got=%b exp=%b", v, anomaly, got.anom);
    end
    @(negedge clk);
`ifdef ANOMALY_STICKY_EN
    anomalyClear = 1'b0;
`endif
    n_tests++;
    if (resultValid !== 1'b0) begin
      n_fail++;
      $display("FAIL rv_pulse sample=%0d got=%b exp=0", v, resultValid);
    end
    n_tests++;
    if (anomaly !== got.anom) begin
      n_fail++;
      $display("FAIL anomaly_hold sample=%0d got=%b exp=%b", v, anomaly, got.anom);
    end
    n_tests++;
    if (average !== got.avg) begin
      n_fail++;
      $display("FAIL average sample=%0d got=%0d exp=%0d", v, average, got.avg);
    end
    n_tests++;
    if (averageValid !== got.avgv) begin
      n_fail++;
      $display("FAIL averageValid sample=%0d got=%b exp=%b", v, averageValid, got.avgv);
    end
    repeat (gap) @(negedge clk);
  endtask

  task automatic fill_window(input int v);
    for (int i = 0; i < DEPTH; i++) send(v, 1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    temperatureReady = 1'b0;
    temperature = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({average, averageValid, resultValid, anomaly, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got avg=%0d av=%b rv=%b an=%b ov=%b exp all 0",
               average, averageValid, resultValid, anomaly, overrun);
    end
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_fill();
    fill_window(1000);
    n_tests++;
    if (averageValid !== 1'b1 || average !== 16'd1000) begin
      n_fail++;
      $display("FAIL fill_done got avg=%0d av=%b exp avg=1000 av=1", average, averageValid);
    end
  endtask

  task automatic test_boundary();
    send(1256, 1);
    n_tests++;
    if (anomaly !== 1'b0) begin
      n_fail++;
      $display("FAIL boundary_eq got=%b exp=0", anomaly);
    end
    do_reset();
    fill_window(1000);
    send(743, 1);
    n_tests++;
    if (anomaly !== 1'b1) begin
      n_fail++;
      $display("FAIL boundary_over got=%b exp=1", anomaly);
    end
  endtask

  task automatic test_update();
    do_reset();
    fill_window(1000);
    send(1300, 1);
    n_tests++;
    if (anomaly !== 1'b1 || average !== 16'd1018) begin
      n_fail++;
      $display("FAIL update got an=%b avg=%0d exp an=1 avg=1018", anomaly, average);
    end
  endtask

  task automatic test_overrun();
    exp_t e;
    do_reset();
    fill_window(1000);
    @(negedge clk);
    temperature = 16'd1100;
    temperatureReady = 1'b1;
    model_accept(1100, e);
    @(posedge clk);
    #1 temperature = 16'd3000;
    @(negedge clk);
    n_tests++;
    if (resultValid !== 1'b1 || overrun !== 1'b0 || anomaly !== e.anom) begin
      n_fail++;
      $display("FAIL overrun_accept got rv=%b ov=%b an=%b exp rv=1 ov=0 an=%b",
               resultValid, overrun, anomaly, e.anom);
    end
    @(posedge clk);
    #1 temperatureReady = 1'b0;
    @(negedge clk);
    n_tests++;
    if (overrun !== 1'b1 || resultValid !== 1'b0 || average !== 16'd1006) begin
      n_fail++;
      $display("FAIL overrun_drop got ov=%b rv=%b avg=%0d exp ov=1 rv=0 avg=1006",
               overrun, resultValid, average);
    end
    @(negedge clk);
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_pulse got=%b exp=0", overrun);
    end
    send(1000, 1);
  endtask

  task automatic test_reset_mid_update();
    fill_window(1000);
    @(negedge clk);
    temperature = 16'd2000;
    temperatureReady = 1'b1;
    @(posedge clk);
    #1 temperatureReady = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_tests++;
    if ({average, averageValid, resultValid, anomaly, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got avg=%0d av=%b rv=%b an=%b ov=%b exp all 0",
               average, averageValid, resultValid, anomaly, overrun);
    end
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < DEPTH - 1; i++) send(500 + 7 * i, 0);
    n_tests++;
    if (averageValid !== 1'b0) begin
      n_fail++;
      $display("FAIL refill_early got=%b exp=0", averageValid);
    end
    send(600, 0);
    n_tests++;
    if (averageValid !== 1'b1) begin
      n_fail++;
      $display("FAIL refill_done got=%b exp=1", averageValid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 48; i++) send(int'($urandom_range(500, 1500)), 0);
  endtask

`ifdef ANOMALY_STICKY_EN
  task automatic test_sticky();
    do_reset();
    fill_window(1000);
    send(1300, 1);
    for (int i = 0; i < 5; i++) send(1018, 1);
    n_tests++;
    if (anomalyLatched !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_hold got=%b exp=1", anomalyLatched);
    end
    clr_with_rv = 1'b1;
    send(3000, 1);
    clr_with_rv = 1'b0;
    n_tests++;
    if (anomalyLatched !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_setclr got=%b exp=1", anomalyLatched);
    end
    @(negedge clk);
    anomalyClear = 1'b1;
    @(negedge clk);
    anomalyClear = 1'b0;
    n_tests++;
    if (anomalyLatched !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear got=%b exp=0", anomalyLatched);
    end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef ANOMALY_STICKY_EN
    anomalyClear = 1'b0;
`endif
    test_reset();
    test_fill();
    test_boundary();
    test_update();
    test_overrun();
    test_reset_mid_update();
    test_back_to_back();
`ifdef ANOMALY_STICKY_EN
    test_sticky();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
